fetch_queue: RTL

- Instruction fetch front end for the RV core; sits directly upstream of decode and the immediate extender.
- Owns the PC register and issues in-order word requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned words, each tagged with its PC, in a small circular queue and presents them to decode through a valid/ready handshake.
- Supports a redirect (branch/jump target) that flushes the queue and discards stale in-flight responses.

---
 rtl/fetch_queue.sv | 105 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: owns the PC, issues in-order word fetches and buffers PC-tagged
// instructions for decode; redirects flush the queue and drop stale responses.
module fetch_queue #(
  parameter int unsigned   AW       = 32,
  parameter int unsigned   DW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int unsigned   DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [AW-1:0] imem_req_addr,
  input  logic          imem_rsp_valid,
  input  logic [DW-1:0] imem_rsp_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_instr,
  output logic [AW-1:0] out_pc
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0]    fetch_pc;
  logic [CW-1:0]    head, tail, fill_ptr, drop_cnt;
  logic [AW-1:0]    pc_q    [DEPTH];
  logic [DW-1:0]    instr_q [DEPTH];
  logic [DEPTH-1:0] filled;
  logic             rst_prev;

  logic [CW-1:0] alloc_count, unfilled, redirect_drop;
  logic [PW-1:0] head_idx, tail_idx, fill_idx;
  logic          accept, pop, rsp_fill, rsp_discard;

  always_comb begin
    head_idx    = head[PW-1:0];
    tail_idx    = tail[PW-1:0];
    fill_idx    = fill_ptr[PW-1:0];
    alloc_count = tail - head;
    unfilled    = tail - fill_ptr;

    imem_req_valid = !rst_prev && ((alloc_count + drop_cnt) < CW'(DEPTH));
    imem_req_addr  = fetch_pc;
    accept         = imem_req_valid && imem_req_ready;

    out_valid = filled[head_idx];
    out_instr = instr_q[head_idx];
    out_pc    = pc_q[head_idx];
    pop       = out_valid && out_ready;

    // A response landing in the redirect cycle belongs to a now-dead entry.
    rsp_discard = imem_rsp_valid && ((drop_cnt != '0) || redirect_valid);
    rsp_fill    = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

    // In-flight after redirect: unfilled entries, plus this cycle's request,
    // plus already-pending drops, minus whichever response retires this cycle.
    redirect_drop = unfilled + drop_cnt + {{PW{1'b0}}, accept}
                    - {{PW{1'b0}}, imem_rsp_valid};
  end

  always_ff @(posedge clk) begin
    rst_prev <= rst;
    if (rst) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      fill_ptr <= '0;
      drop_cnt <= '0;
      filled   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      if (accept) pc_q[tail_idx] <= fetch_pc;
      if (rsp_fill) instr_q[fill_idx] <= imem_rsp_data;

      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[AW-1:2], 2'b00};
        head     <= '0;
        tail     <= '0;
        fill_ptr <= '0;
        filled   <= '0;
        drop_cnt <= redirect_drop;
      end else begin
        if (accept) begin
          fetch_pc         <= fetch_pc + AW'(4);
          tail             <= tail + CW'(1);
          filled[tail_idx] <= 1'b0;
        end
        if (rsp_fill) begin
          fill_ptr         <= fill_ptr + CW'(1);
          filled[fill_idx] <= 1'b1;
        end
        if (pop) begin
          head             <= head + CW'(1);
          filled[head_idx] <= 1'b0;
        end
        if (rsp_discard) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end
endmodule
